alu_multiciclo: RTL

//  Parametrised multi-cycle ALU; successor of the 32-bit combinational ALU.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_iter.sv | 66 ++++++
 rtl/alu_multiciclo.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings and FSM states.
package alu_pkg;

    // Operation codes presented on AluOp
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Control states: waiting for work, iterating a multiply, holding a result
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_t;

    // True when the opcode needs the iterative multiplier
    function automatic logic is_multicycle(input logic [2:0] op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH steps.
// 'done' pulses combinationally during the final step and 'product' shows
// the value being accumulated on that edge, so the caller can capture the
// finished product on the same edge the counter reaches zero.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      count_reg;
    logic               busy_reg;

    // Conditional add of the shifted multiplicand for the current multiplier bit
    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
        end
    end

    assign busy    = busy_reg;
    assign done    = busy_reg && (count_reg == CW'(1));
    assign product = acc_next;

    // Operand load on start, then one shift-add step per cycle until the count runs out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, multiplicand};
            mplier_reg <= multiplier;
            count_reg  <= CW'(WIDTH);
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
            count_reg  <= count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU with valid/ready handshakes on both sides and a registered
// result. Single-cycle ops finish on the accept edge; MUL iterates WIDTH
// cycles in alu_mul_iter. One operation in flight at a time.
// Optional build macro ALU_FLAGS_EN adds the Cero/Acarreo/Desbordamiento flags.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Ope1,
    input  logic [WIDTH-1:0] Ope2,
    input  logic [2:0]       AluOp,
    input  logic             InValido,
    output logic             InListo,
    output logic [WIDTH-1:0] Resultado,
    output logic             OutValido,
`ifdef ALU_FLAGS_EN
    output logic             Cero,
    output logic             Acarreo,
    output logic             Desbordamiento,
`endif
    input  logic             OutListo
);

    state_t state_reg;
    state_t state_next;

    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   and_v;
    logic [WIDTH-1:0]   or_v;
    logic [WIDTH-1:0]   xor_v;
    logic [WIDTH-1:0]   nor_v;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [WIDTH-1:0]   op_result;
    logic [WIDTH-1:0]   result_reg;

    assign InListo   = (state_reg == IDLE);
    assign OutValido = (state_reg == DONE);
    assign Resultado = result_reg;

    assign accept    = InValido && InListo;
    assign mul_start = accept && is_multicycle(AluOp);

    // Per-bit logic slice
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_v[gi] = Ope1[gi] & Ope2[gi];
            assign or_v[gi]  = Ope1[gi] | Ope2[gi];
            assign xor_v[gi] = Ope1[gi] ^ Ope2[gi];
            assign nor_v[gi] = ~(Ope1[gi] | Ope2[gi]);
        end
    endgenerate

    // One extra bit keeps the carry-out of ADD and the borrow of SUB
    assign add_ext = {1'b0, Ope1} + {1'b0, Ope2};
    assign sub_ext = {1'b0, Ope1} - {1'b0, Ope2};

    // Single-cycle result mux; the borrow bit doubles as the unsigned less-than
    always_comb begin
        op_result = '0;
        case (AluOp)
            OP_AND:  op_result = and_v;
            OP_OR:   op_result = or_v;
            OP_ADD:  op_result = add_ext[WIDTH-1:0];
            OP_XOR:  op_result = xor_v;
            OP_NOR:  op_result = nor_v;
            OP_SUB:  op_result = sub_ext[WIDTH-1:0];
            OP_SLT:  op_result = {{(WIDTH-1){1'b0}}, sub_ext[WIDTH]};
            default: op_result = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (mul_start),
        .multiplicand (Ope1),
        .multiplier   (Ope2),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; handoff in DONE returns to IDLE so no accept overlaps it
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (InValido) begin
                    state_next = is_multicycle(AluOp) ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_done && mul_busy) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (OutListo) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result register: written on a single-cycle accept or on the final multiply step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= '0;
        end else if (accept && !is_multicycle(AluOp)) begin
            result_reg <= op_result;
        end else if ((state_reg == MUL) && mul_done) begin
            result_reg <= mul_product[WIDTH-1:0];
        end
    end

`ifdef ALU_FLAGS_EN
    logic op_carry;
    logic op_ovf;
    logic cero_reg;
    logic acarreo_reg;
    logic desb_reg;

    assign Cero           = cero_reg;
    assign Acarreo        = acarreo_reg;
    assign Desbordamiento = desb_reg;

    // Carry/borrow and signed overflow for the single-cycle arithmetic ops
    always_comb begin
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        case (AluOp)
            OP_ADD: begin
                op_carry = add_ext[WIDTH];
                op_ovf   = (Ope1[WIDTH-1] == Ope2[WIDTH-1]) &&
                           (add_ext[WIDTH-1] != Ope1[WIDTH-1]);
            end
            OP_SUB: begin
                op_carry = sub_ext[WIDTH];
                op_ovf   = (Ope1[WIDTH-1] != Ope2[WIDTH-1]) &&
                           (sub_ext[WIDTH-1] != Ope1[WIDTH-1]);
            end
            default: begin
                op_carry = 1'b0;
                op_ovf   = 1'b0;
            end
        endcase
    end

    // Flag registers track the result register write for write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cero_reg    <= 1'b0;
            acarreo_reg <= 1'b0;
            desb_reg    <= 1'b0;
        end else if (accept && !is_multicycle(AluOp)) begin
            cero_reg    <= (op_result == '0);
            acarreo_reg <= op_carry;
            desb_reg    <= op_ovf;
        end else if ((state_reg == MUL) && mul_done) begin
            cero_reg    <= (mul_product[WIDTH-1:0] == '0);
            acarreo_reg <= 1'b0;
            desb_reg    <= (mul_product[2*WIDTH-1:WIDTH] != '0);
        end
    end
`endif

endmodule
